// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant
// identities and a small state-classification helper.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DATA  = 3'd1,
      INSTR = 3'd2,
      RESP  = 3'd3,
      ERROR = 3'd4
   } state_t;

   typedef enum logic {
      GRANT_DATA  = 1'b0,
      GRANT_INSTR = 1'b1
   } grant_t;

   localparam int DEFAULT_TIMEOUT = 15;

   // True while a bus transfer is outstanding.
   function automatic logic is_bus_state(input state_t s);
      return (s == DATA) || (s == INSTR);
   endfunction

endpackage

// File: rtl/arbiter_watchdog.sv
// Bus-wait watchdog: counts cycles without ack during a transfer and flags
// the cycle in which the TIMEOUT-th unacknowledged cycle completes.
module arbiter_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic ack,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Saturates at TIMEOUT so the counter can never wrap back to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !ack && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && !ack && (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data access) arbiter onto a single memory
// bus with alternating tie-break, response pulse and sticky timeout error.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ifReq,
   input  logic [31:0] ifAddress,
   output logic        ifReady,
   output logic [31:0] ifData,
   input  logic        memReq,
   input  logic        memWrite,
   input  logic [31:0] memAddress,
   input  logic [31:0] memWriteData,
   output logic        memReady,
   output logic [31:0] memReadData,
   output logic        busReq,
   output logic        busWrite,
   output logic [31:0] busAddress,
   output logic [31:0] busWriteData,
   input  logic        busAck,
   input  logic [31:0] busReadData,
   output logic        stallPipeline,
   output logic        busError,
   output state_t      fsm_state
);

   // Handshake: a requester raises its req level and may drop it at any time;
   // once sampled in IDLE the transfer always completes and the matching
   // ready pulses for exactly one cycle. On the bus side busReq is held with
   // stable address/data until a cycle with busAck high, which ends it.

   state_t state, state_next;
   grant_t last_grant;
   logic   start_data, start_instr;
   logic   wd_expired;

   always_comb begin
      state_next  = state;
      start_data  = 1'b0;
      start_instr = 1'b0;
      case (state)
         IDLE: begin
            if (memReq && (!ifReq || (last_grant == GRANT_INSTR))) begin
               start_data = 1'b1;
               state_next = DATA;
            end else if (ifReq) begin
               start_instr = 1'b1;
               state_next  = INSTR;
            end
         end
         DATA, INSTR: begin
            if (busAck) begin
               state_next = RESP;
            end else if (wd_expired) begin
               state_next = ERROR;
            end
         end
         RESP:    state_next = IDLE;
         ERROR:   state_next = ERROR;
         default: state_next = IDLE;
      endcase
   end

   // last_grant doubles as the owner of the transfer in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= GRANT_INSTR;
      end else begin
         state <= state_next;
         if (start_data) begin
            last_grant <= GRANT_DATA;
         end else if (start_instr) begin
            last_grant <= GRANT_INSTR;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busAddress   <= '0;
         busWrite     <= 1'b0;
         busWriteData <= '0;
      end else if (start_data) begin
         busAddress   <= memAddress;
         busWrite     <= memWrite;
         busWriteData <= memWrite ? memWriteData : 32'h0;
      end else if (start_instr) begin
         busAddress   <= ifAddress;
         busWrite     <= 1'b0;
         busWriteData <= 32'h0;
      end
   end

   // Result registers only move on a completed transfer of their own kind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifData      <= '0;
         memReadData <= '0;
      end else begin
         if ((state == DATA) && busAck && !busWrite) begin
            memReadData <= busReadData;
         end
         if ((state == INSTR) && busAck) begin
            ifData <= busReadData;
         end
      end
   end

   arbiter_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_data | start_instr),
      .enable  (busReq),
      .ack     (busAck),
      .expired (wd_expired)
   );

   assign busReq        = is_bus_state(state);
   assign ifReady       = (state == RESP) && (last_grant == GRANT_INSTR);
   assign memReady      = (state == RESP) && (last_grant == GRANT_DATA);
   assign busError      = (state == ERROR);
   assign stallPipeline = (ifReq & ~ifReady) | (memReq & ~memReady) | busError;
   assign fsm_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bus responder, transfer scoreboard and
// hand-computed expectations for arbitration, latency, timeout and reset.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ifReq = 1'b0;
   logic [31:0] ifAddress = '0;
   logic        ifReady;
   logic [31:0] ifData;
   logic        memReq = 1'b0;
   logic        memWrite = 1'b0;
   logic [31:0] memAddress = '0;
   logic [31:0] memWriteData = '0;
   logic        memReady;
   logic [31:0] memReadData;
   logic        busReq;
   logic        busWrite;
   logic [31:0] busAddress;
   logic [31:0] busWriteData;
   logic        busAck;
   logic [31:0] busReadData;
   logic        stallPipeline;
   logic        busError;
   state_t      fsm_state;

   int tests_run = 0;
   int tests_failed = 0;
   logic [64:0] exp_q[$];
   int if_ready_cnt = 0;
   int mem_ready_cnt = 0;

   // Bus responder controls.
   bit          ack_en = 1'b1;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   logic        resp_ack = 1'b0;
   logic        ack_force = 1'b0;
   logic [31:0] rdata = '0;
   logic        busreq_q = 1'b0;

   assign busAck      = resp_ack | ack_force;
   assign busReadData = rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(15)) dut (
      .clk           (clk),
      .reset         (reset),
      .ifReq         (ifReq),
      .ifAddress     (ifAddress),
      .ifReady       (ifReady),
      .ifData        (ifData),
      .memReq        (memReq),
      .memWrite      (memWrite),
      .memAddress    (memAddress),
      .memWriteData  (memWriteData),
      .memReady      (memReady),
      .memReadData   (memReadData),
      .busReq        (busReq),
      .busWrite      (busWrite),
      .busAddress    (busAddress),
      .busWriteData  (busWriteData),
      .busAck        (busAck),
      .busReadData   (busReadData),
      .stallPipeline (stallPipeline),
      .busError      (busError),
      .fsm_state     (fsm_state)
   );

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Waits for either ready pulse; n counts negedges, stall_low counts
   // waiting cycles where the pipeline was not stalled.
   task automatic wait_ready(output int n, output logic got_if, output logic got_mem,
                             output int stall_low);
      n = 0;
      got_if = 1'b0;
      got_mem = 1'b0;
      stall_low = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (ifReady || memReady) begin
            got_if  = ifReady;
            got_mem = memReady;
            break;
         end
         if (!stallPipeline) stall_low++;
      end
   endtask

   // Acks after ack_delay bus cycles without ack (0 = same cycle).
   always @(negedge clk) begin
      if (busReq && ack_en) begin
         resp_ack = (wait_cnt >= ack_delay);
         wait_cnt++;
      end else begin
         resp_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   // Scoreboard: each new bus transfer must match the next expected
   // {write, address, write data}.
   always @(negedge clk) begin
      if (ifReady) if_ready_cnt++;
      if (memReady) mem_ready_cnt++;
      if (busReq && !busreq_q) begin
         check("bus_xfer_queued", 65'(exp_q.size() != 0), 65'(1));
         if (exp_q.size() != 0)
            check("bus_xfer", {busWrite, busAddress, busWriteData}, exp_q.pop_front());
      end
      busreq_q = busReq;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int   n;
      int   stall_low;
      int   if_snap;
      int   mem_snap;
      logic gi;
      logic gm;

      step(2);
      check("rst_state", 65'(fsm_state), 65'(IDLE));
      check("rst_busreq", 65'(busReq), 65'(0));
      check("rst_busaddr", 65'(busAddress), 65'(0));
      check("rst_buswdata", 65'(busWriteData), 65'(0));
      check("rst_ifdata", 65'(ifData), 65'(0));
      check("rst_memrdata", 65'(memReadData), 65'(0));
      check("rst_buserror", 65'(busError), 65'(0));
      check("rst_stall", 65'(stallPipeline), 65'(0));

      // Both requesters pending out of reset: store wins the first tie.
      memReq = 1'b1; memWrite = 1'b1; memAddress = 32'h1001_0000;
      memWriteData = 32'hDEAD_BEEF;
      ifReq = 1'b1; ifAddress = 32'h0040_0000;
      ack_en = 1'b1; ack_delay = 0; rdata = 32'hCAFE_F00D;
      exp_q.push_back({1'b1, 32'h1001_0000, 32'hDEAD_BEEF});
      exp_q.push_back({1'b0, 32'h0040_0000, 32'h0});
      reset = 1'b1;
      wait_ready(n, gi, gm, stall_low);
      check("tie_first_latency", 65'(n), 65'(2));
      check("tie_first_mem", 65'({gm, gi}), 65'(2'b10));
      check("store_no_capture", 65'(memReadData), 65'(0));
      wait_ready(n, gi, gm, stall_low);
      check("tie_second_latency", 65'(n), 65'(3));
      check("tie_second_if", 65'({gm, gi}), 65'(2'b01));
      check("tie_ifdata", 65'(ifData), 65'(32'hCAFE_F00D));
      memReq = 1'b0; ifReq = 1'b0; memWrite = 1'b0;
      step(1);
      check("ready_single_pulse", 65'(ifReady), 65'(0));

      // Single fetch, ack one cycle after busReq.
      ack_delay = 1; rdata = 32'h2008_0005;
      ifReq = 1'b1; ifAddress = 32'h0040_0000;
      exp_q.push_back({1'b0, 32'h0040_0000, 32'h0});
      wait_ready(n, gi, gm, stall_low);
      check("fetch_latency", 65'(n), 65'(3));
      check("fetch_ifready", 65'({gm, gi}), 65'(2'b01));
      check("fetch_ifdata", 65'(ifData), 65'(32'h2008_0005));
      check("fetch_stall_wait", 65'(stall_low), 65'(0));
      check("fetch_stall_ready", 65'(stallPipeline), 65'(0));
      ifReq = 1'b0;
      step(1);
      check("fetch_back_idle", 65'(fsm_state), 65'(IDLE));

      // Both held for four transfers: grants alternate D, I, D, I.
      ack_delay = 0; memWrite = 1'b0; memAddress = 32'h1001_0040;
      memWriteData = 32'h5555_5555; ifAddress = 32'h0040_0004;
      for (int k = 0; k < 4; k++)
         exp_q.push_back((k % 2 == 0) ? {1'b0, 32'h1001_0040, 32'h0}
                                      : {1'b0, 32'h0040_0004, 32'h0});
      memReq = 1'b1; ifReq = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rdata = 32'hA000_0000 + 32'(k);
         wait_ready(n, gi, gm, stall_low);
         check("alt_latency", 65'(n), 65'((k == 0) ? 2 : 3));
         check("alt_stall_wait", 65'(stall_low), 65'(0));
         if (k % 2 == 0) begin
            check("alt_grant_data", 65'({gm, gi}), 65'(2'b10));
            check("alt_memrdata", 65'(memReadData), 65'(32'hA000_0000 + 32'(k)));
         end else begin
            check("alt_grant_instr", 65'({gm, gi}), 65'(2'b01));
            check("alt_ifdata", 65'(ifData), 65'(32'hA000_0000 + 32'(k)));
         end
      end
      memReq = 1'b0; ifReq = 1'b0;
      step(1);

      // Load whose request drops mid-transfer still completes.
      ack_delay = 2; rdata = 32'h0BAD_F00D;
      memReq = 1'b1; memWrite = 1'b0; memAddress = 32'h1001_0080;
      exp_q.push_back({1'b0, 32'h1001_0080, 32'h0});
      step(1);
      check("drop_in_data", 65'(fsm_state), 65'(DATA));
      memReq = 1'b0;
      wait_ready(n, gi, gm, stall_low);
      check("drop_latency", 65'(n), 65'(3));
      check("drop_memready", 65'({gm, gi}), 65'(2'b10));
      check("drop_memrdata", 65'(memReadData), 65'(32'h0BAD_F00D));
      step(1);

      // Stray busAck in IDLE is ignored.
      if_snap = if_ready_cnt; mem_snap = mem_ready_cnt;
      ack_force = 1'b1;
      step(1);
      ack_force = 1'b0;
      step(2);
      check("stray_ack_state", 65'(fsm_state), 65'(IDLE));
      check("stray_ack_busreq", 65'(busReq), 65'(0));
      check("stray_ack_ifready", 65'(if_ready_cnt), 65'(if_snap));
      check("stray_ack_memready", 65'(mem_ready_cnt), 65'(mem_snap));
      check("stray_ack_ifdata", 65'(ifData), 65'(32'hA000_0003));
      check("stray_ack_memrdata", 65'(memReadData), 65'(32'h0BAD_F00D));

      // Reset while a fetch waits on the bus.
      ack_en = 1'b0;
      ifReq = 1'b1; ifAddress = 32'h0040_0100;
      exp_q.push_back({1'b0, 32'h0040_0100, 32'h0});
      step(2);
      check("midrst_in_instr", 65'(fsm_state), 65'(INSTR));
      #2 reset = 1'b0;
      #1;
      check("midrst_state", 65'(fsm_state), 65'(IDLE));
      check("midrst_busreq", 65'(busReq), 65'(0));
      check("midrst_busaddr", 65'(busAddress), 65'(0));
      check("midrst_ifdata", 65'(ifData), 65'(0));
      check("midrst_memrdata", 65'(memReadData), 65'(0));
      ifReq = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      if_snap = if_ready_cnt;
      step(3);
      check("midrst_no_ifready", 65'(if_ready_cnt), 65'(if_snap));
      ack_en = 1'b1; ack_delay = 0; rdata = 32'h1234_5678;
      ifReq = 1'b1; ifAddress = 32'h0040_0200;
      exp_q.push_back({1'b0, 32'h0040_0200, 32'h0});
      wait_ready(n, gi, gm, stall_low);
      check("postrst_latency", 65'(n), 65'(2));
      check("postrst_ifready", 65'({gm, gi}), 65'(2'b01));
      check("postrst_ifdata", 65'(ifData), 65'(32'h1234_5678));
      ifReq = 1'b0;
      step(1);

      // Load that is never acknowledged: ERROR after 15 bus cycles.
      ack_en = 1'b0;
      memReq = 1'b1; memWrite = 1'b0; memAddress = 32'h1001_0100;
      exp_q.push_back({1'b0, 32'h1001_0100, 32'h0});
      if_snap = if_ready_cnt; mem_snap = mem_ready_cnt;
      step(15);
      check("to_last_bus_cycle", 65'(fsm_state), 65'(DATA));
      check("to_busreq_held", 65'(busReq), 65'(1));
      step(1);
      check("to_error_state", 65'(fsm_state), 65'(ERROR));
      check("to_buserror", 65'(busError), 65'(1));
      check("to_busreq_drop", 65'(busReq), 65'(0));
      memReq = 1'b0;
      #1;
      check("to_stall_sticky", 65'(stallPipeline), 65'(1));
      ifReq = 1'b1; ack_force = 1'b1;
      step(1);
      ack_force = 1'b0;
      step(3);
      check("to_terminal", 65'(fsm_state), 65'(ERROR));
      check("to_ignores_req", 65'(busReq), 65'(0));
      check("to_no_memready", 65'(mem_ready_cnt), 65'(mem_snap));
      check("to_no_ifready", 65'(if_ready_cnt), 65'(if_snap));
      ifReq = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("to_rst_state", 65'(fsm_state), 65'(IDLE));
      check("to_rst_buserror", 65'(busError), 65'(0));
      check("to_rst_stall", 65'(stallPipeline), 65'(0));
      @(negedge clk);
      reset = 1'b1;
      step(2);

      check("scoreboard_drained", 65'(exp_q.size()), 65'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum bus wait cycles per transfer before error.
REQ-002 Ports: clk in 1 (system clock); reset in 1 (asynchronous, active-low).
REQ-003 ifReq in 1 (fetch request); ifAddress in 32; ifReady out 1 (fetch done pulse); ifData out 32 (fetched instruction).
REQ-004 memReq in 1 (data request); memWrite in 1 (1=store); memAddress in 32; memWriteData in 32; memReady out 1 (data done pulse); memReadData out 32.
REQ-005 busReq out 1; busWrite out 1; busAddress out 32; busWriteData out 32; busAck in 1 (transfer complete); busReadData in 32.
REQ-006 stallPipeline out 1 (freeze IF/ID/EX stages); busError out 1 (sticky timeout flag).

Function
REQ-007 The FSM SHALL have states IDLE, DATA, INSTR, RESP, ERROR.
REQ-008 In IDLE, if exactly one request is high, the arbiter SHALL go to DATA (memReq) or INSTR (ifReq) next cycle.
REQ-009 If both requests are high in IDLE, the grant SHALL go to the requester not granted last (lastGrant register, reset value INSTR, so the first tie goes to DATA).
REQ-010 On the IDLE->grant edge, the address, busWrite and write data SHALL be latched into bus registers and held constant until the transfer ends.
REQ-011 In DATA/INSTR, busReq SHALL be 1; busWrite SHALL be memWrite latched (DATA) or 0 (INSTR).
REQ-012 On busAck in DATA/INSTR, busReadData SHALL be captured into memReadData (DATA, loads only) or ifData (INSTR), busReq SHALL drop next cycle, and the state SHALL go to RESP.
REQ-013 In RESP, exactly one of memReady/ifReady (the granted one) SHALL be 1 for one cycle; the next state SHALL be IDLE.
REQ-014 Minimum request-to-ready latency SHALL be 3 cycles (IDLE sample, bus cycle with same-cycle busAck, RESP).
REQ-015 ifData and memReadData SHALL hold their values until the next completed transfer of the same kind.
REQ-016 stallPipeline SHALL be combinational: (ifReq & ~ifReady) | (memReq & ~memReady) | busError.
REQ-017 A request deasserted mid-transfer SHALL NOT abort it; the transfer completes and the ready pulse is still issued.
REQ-018 A watchdog counter SHALL clear on entry to DATA/INSTR and increment each cycle without busAck.
REQ-019 When the counter reaches TIMEOUT without busAck, the state SHALL go to ERROR, busReq SHALL drop, and no ready pulse SHALL be issued.
REQ-020 ERROR SHALL be terminal until reset; busError=1 in ERROR, busReq=0, all requests ignored.
REQ-021 busAck outside DATA/INSTR SHALL be ignored.
REQ-022 The counter width SHALL be $clog2(TIMEOUT+1) and it SHALL never wrap.

Reset
REQ-023 On reset low (any state, any cycle), the arbiter SHALL go to IDLE immediately, with lastGrant=INSTR, counter=0, and all outputs 0 (ifData=memReadData=0, busAddress=busWriteData=0).
REQ-024 A transfer in flight during reset SHALL be abandoned with no ready pulse; the first request is sampled on the first clk edge after reset rises.

Structure
REQ-025 The state enum (IDLE, DATA, INSTR, RESP, ERROR) and grant enum (GRANT_DATA, GRANT_INSTR) SHALL live in shared package mem_arbiter_pkg.
REQ-026 The watchdog SHALL be a sub-module arbiter_watchdog (inputs clear/enable/ack, output expired, parameter TIMEOUT).
REQ-027 All state, bus and data-output registers SHALL share the single clk domain with asynchronous active-low reset.

Verification
REQ-028 Only ifReq=1, ifAddress=0x00400000, busAck 1 cycle after busReq, busReadData=0x20080005 -> busAddress=0x00400000, busWrite=0, ifReady pulse, ifData=0x20080005.
REQ-029 ifReq and memReq both high from reset, memWrite=1, memAddress=0x10010000, memWriteData=0xDEADBEEF -> DATA first with bus write 0xDEADBEEF, memReady; then INSTR, ifReady.
REQ-030 Both requests held for 4 transfers -> grants alternate DATA, INSTR, DATA, INSTR; stallPipeline=1 except in ready cycles.
REQ-031 memReq load, busAck never asserted, TIMEOUT=15 -> ERROR after 15 bus cycles, busError=1, busReq=0, no memReady, stallPipeline=1 until reset.
REQ-032 Reset pulsed low while in INSTR waiting on busAck -> immediate IDLE, outputs 0, no ifReady; a later ifReq completes normally.
REQ-033 busAck pulsed in IDLE with no request -> no state change, no ready pulse, data outputs unchanged.
